// File: rtl/bch_syndrome_engine.sv
// BCH syndrome engine: accumulates the odd syndromes S1, S3, ..., S(2*NSYN-1)
// of an N-bit codeword that streams in BITS bits per beat, highest-degree bit
// first. It uses a Horner-style recurrence in GF(2^M) with constant
// multipliers and a one-deep output register with a HOLD state for
// back-pressure.
module bch_syndrome_engine #(
    parameter int         M     = 4,
    parameter logic [M:0] POLY  = 5'b10011,
    parameter int         N     = 15,
    parameter int         BITS  = 1,
    parameter int         NSYN  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic                  in_first,
    input  logic [BITS-1:0]       data_in,
    output logic                  in_ready,
    output logic [NSYN*M-1:0]     syn_out,
    output logic                  syn_valid,
    input  logic                  syn_ready,
    output logic                  syn_nonzero,
    output logic                  frame_err
);

    // Field order, beats per codeword and bits used by the first beat.
    localparam int ORD = (1 << M) - 1;
    localparam int B   = (N + BITS - 1) / BITS;
    localparam int R   = N - (B - 1) * BITS;
    localparam int CW  = (B > 1) ? $clog2(B) : 1;

    // The first beat only carries the low R bits of the codeword.
    localparam logic [BITS-1:0] FIRST_MASK = {BITS{1'b1}} >> (BITS - R);

    // Multiply a field element by alpha (= x) and reduce modulo POLY.
    function automatic logic [M-1:0] gf_xtime(input logic [M-1:0] a);
        logic [M-1:0] r;
        r = {a[M-2:0], 1'b0};
        if (a[M-1]) begin
            r = r ^ POLY[M-1:0];
        end
        return r;
    endfunction

    // General GF(2^M) product. In this design one operand is always an
    // elaboration-time constant, so it reduces to a fixed XOR network.
    function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a,
                                            input logic [M-1:0] b);
        logic [M-1:0] p;
        logic [M-1:0] s;
        p = '0;
        s = a;
        for (int i = 0; i < M; i++) begin
            if (b[i]) begin
                p = p ^ s;
            end
            s = gf_xtime(s);
        end
        return p;
    endfunction

    // alpha^e, where the exponent is reduced modulo the multiplicative order.
    function automatic logic [M-1:0] gf_alpha_pow(input int e);
        logic [M-1:0] r;
        int           n;
        r = {{(M-1){1'b0}}, 1'b1};
        n = e % ORD;
        for (int i = 0; i < n; i++) begin
            r = gf_xtime(r);
        end
        return r;
    endfunction

    // Per-bit input weights alpha^(j*k) for channel j, packed k-major.
    function automatic logic [BITS*M-1:0] gen_taps(input int j);
        logic [BITS*M-1:0] t;
        t = '0;
        for (int k = 0; k < BITS; k++) begin
            t[k*M +: M] = gf_alpha_pow(j * k);
        end
        return t;
    endfunction

    // Reject parameter sets the datapath cannot represent.
    if (M < 2 || N < 2 || N > ORD || BITS < 1 || BITS > N || NSYN < 1) begin : g_bad_params
        $error("bch_syndrome_engine: illegal parameter set");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t               state_q,     state_d;
    logic [CW-1:0]        count_q,     count_d;
    logic [NSYN*M-1:0]    acc_q,       acc_d;
    logic [NSYN*M-1:0]    syn_out_q,   syn_out_d;
    logic                 syn_valid_q, syn_valid_d;
    logic                 in_ready_q,  in_ready_d;
    logic                 frame_err_q, frame_err_d;

    logic                 accept;
    logic                 beat_first;
    logic                 beat_live;
    logic                 last_beat;
    logic                 out_free;
    logic [BITS-1:0]      beat_data;
    logic [NSYN*M-1:0]    acc_next;

    // Beat qualification. in_ready_q is already low in HOLD, so accept never
    // fires there.
    assign accept     = in_valid && in_ready_q;
    assign beat_first = accept && in_first;
    assign beat_live  = accept && (in_first || (state_q == S_ACCUM));
    assign beat_data  = beat_first ? (data_in & FIRST_MASK) : data_in;
    assign last_beat  = beat_live &&
                        (in_first ? (B == 1) : (count_q == CW'(B - 1)));
    assign out_free   = !syn_valid_q || syn_ready;

    // One Horner step per syndrome channel: acc*alpha^(j*BITS) + sum d[k]*alpha^(j*k).
    genvar gi;
    generate
        for (gi = 0; gi < NSYN; gi++) begin : g_chan
            localparam int                J     = 2 * gi + 1;
            localparam logic [M-1:0]      STEP  = gf_alpha_pow(J * BITS);
            localparam logic [BITS*M-1:0] TAPS  = gen_taps(J);

            logic [M-1:0] fold;
            logic [M-1:0] scaled;

            // XOR together the constant weights of the set input bits in this beat.
            always_comb begin
                fold = '0;
                for (int k = 0; k < BITS; k++) begin
                    if (beat_data[k]) begin
                        fold = fold ^ TAPS[k*M +: M];
                    end
                end
            end

            // A codeword start discards whatever was left in the accumulator.
            assign scaled = beat_first ? '0 : gf_mul(acc_q[gi*M +: M], STEP);
            assign acc_next[gi*M +: M] = scaled ^ fold;
        end
    endgenerate

    // Next-state logic for the IDLE/ACCUM/HOLD controller and the output register.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        acc_d       = acc_q;
        syn_out_d   = syn_out_q;
        syn_valid_d = syn_valid_q;
        frame_err_d = 1'b0;

        if (syn_valid_q && syn_ready) begin
            syn_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE, S_ACCUM: begin
                if (beat_live) begin
                    acc_d = acc_next;
                    if (beat_first && (state_q == S_ACCUM)) begin
                        frame_err_d = 1'b1;
                    end
                    if (last_beat) begin
                        count_d = '0;
                        if (out_free) begin
                            syn_out_d   = acc_next;
                            syn_valid_d = 1'b1;
                            state_d     = S_IDLE;
                        end else begin
                            state_d     = S_HOLD;
                        end
                    end else begin
                        count_d = in_first ? CW'(1) : (count_q + CW'(1));
                        state_d = S_ACCUM;
                    end
                end
            end
            S_HOLD: begin
                if (out_free) begin
                    syn_out_d   = acc_q;
                    syn_valid_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                count_d = '0;
            end
        endcase

        in_ready_d = (state_d != S_HOLD);
    end

    // State registers. in_ready resets low and rises on the first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            acc_q       <= '0;
            syn_out_q   <= '0;
            syn_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            acc_q       <= acc_d;
            syn_out_q   <= syn_out_d;
            syn_valid_q <= syn_valid_d;
            in_ready_q  <= in_ready_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign syn_out     = syn_out_q;
    assign syn_valid   = syn_valid_q;
    assign frame_err   = frame_err_q;
    assign syn_nonzero = syn_valid_q && (|syn_out_q);

endmodule

// File: doc/bch_syndrome_engine.md
BCH_SYNDROME_ENGINE -- requirements
Module: bch_syndrome_engine

Interface
REQ-001 The block SHALL have these parameters:
- M, default 4: GF(2^M) field width.
- POLY, default 5'b10011: primitive polynomial, M+1 bits.
- N, default 15: codeword length in bits, 2 <= N <= 2^M-1.
- BITS, default 1: input bits per beat, 1 <= BITS <= N.
- NSYN, default 2: number of syndromes computed.
- Syndrome indices are fixed at j = 1, 3, ..., 2*NSYN-1.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: the only clock.
- rst_n, in, 1: reset, asynchronous assert, active-low.
- in_valid, in, 1: input beat offered.
- in_first, in, 1: the offered beat is the first beat of a codeword.
- data_in, in, BITS: codeword bits.
- in_ready, out, 1: beat accepted when in_valid && in_ready.
- syn_out, out, NSYN*M: syndrome results; S_(2k+1) sits at [k*M +: M].
- syn_valid, out, 1: syn_out holds a completed result set.
- syn_ready, in, 1: result consumed when syn_valid && syn_ready.
- syn_nonzero, out, 1: OR of all bits of syn_out, qualified by syn_valid.
- frame_err, out, 1: one-cycle pulse when a codeword is aborted.

REQ-003 One clock and one reset only: rst_n is asynchronous and active-low, and no other reset or clock-enable ports exist.

Function
REQ-004 Bit order: codeword bit r_(N-1) arrives first. Within a beat, data_in[BITS-1] is the highest-degree bit.
REQ-005 A codeword SHALL take B = ceil(N/BITS) accepted beats.
REQ-006 The first beat SHALL use only its low R = N-(B-1)*BITS bits; its upper BITS-R bits SHALL be masked to zero.
REQ-007 Each accepted beat SHALL update every channel as acc_j <= acc_j*alpha^(j*BITS) + sum_k data_in[k]*alpha^(j*k). All arithmetic is in GF(2^M) mod POLY with polynomial-basis operands.
REQ-008 On the first beat, the old acc_j SHALL be treated as zero.
REQ-009 All multiplier constants SHALL be elaboration-time constants; no runtime division and no table RAM.
REQ-010 A beat counter SHALL count accepted beats 0..B-1. Accepting beat B-1 completes the codeword.
REQ-011 The FSM SHALL have the states IDLE, ACCUM and HOLD.
REQ-012 IDLE: in_ready=1. A beat with in_first=1 SHALL be accepted and go to ACCUM, or complete the codeword if B==1. A beat with in_first=0 SHALL be accepted and discarded with no state change.
REQ-013 ACCUM: in_ready=1. A beat with in_first=1 SHALL restart accumulation from that beat, set count to 1, and pulse frame_err for one cycle.
REQ-014 On completion, if the output register is empty or is being consumed in the same cycle, the acc values SHALL be copied to syn_out and syn_valid set on the next edge, and the FSM SHALL go to IDLE. Otherwise the FSM SHALL go to HOLD.
REQ-015 HOLD: in_ready=0. When the output register frees, the acc values SHALL transfer to syn_out and the FSM SHALL go to IDLE.
REQ-016 Latency: syn_valid SHALL rise on the edge that accepts the last beat, so results are visible the cycle after that beat.
REQ-017 Back-to-back codewords with syn_ready held at 1 SHALL sustain one beat per cycle with no bubbles.
REQ-018 syn_out SHALL remain stable while syn_valid=1 && syn_ready=0.
REQ-019 syn_valid SHALL clear on consumption unless a new result is loaded on the same edge.
REQ-020 in_ready SHALL depend only on registered state, with no combinational path from syn_ready.

Reset
REQ-021 While rst_n=0, the following SHALL hold immediately and asynchronously:
- FSM = IDLE, beat counter = 0, all acc = 0.
- syn_out = 0, syn_valid = 0, syn_nonzero = 0, frame_err = 0.
- in_ready SHALL be 0 while rst_n=0 and 1 from the first clk edge after release.
REQ-022 A reset mid-codeword SHALL discard the partial codeword. No stale syn_valid SHALL appear after release.

Verification
REQ-023 Defaults. Feed 15 beats of zeros -> syn_out=8'h00, syn_valid=1 one cycle after beat 15, syn_nonzero=0.
REQ-024 Defaults, single error at r_0 (last beat=1) -> S1=4'h1, S3=4'h1, syn_out=8'h11, syn_nonzero=1.
REQ-025 Defaults, error at r_1 (beat 14=1) -> S1=4'h2, S3=4'h8, syn_out=8'h82.
REQ-026 BITS=4, N=15, error at r_1. Beats are 4'b0000 (upper bit is padding; a 1 placed there must be ignored), 0000, 0000, 0010 -> syn_out=8'h82 after 4 beats.
REQ-027 Back-pressure. Hold syn_ready=0 and stream two codewords -> first result held stable, FSM in HOLD, in_ready=0. Raise syn_ready -> second result loads the next cycle and in_ready returns to 1.
REQ-028 Abort and reset:
- in_first asserted at beat 7 -> frame_err pulses once; the result reflects only the new codeword's 15 beats.
- rst_n=0 mid-codeword -> all outputs 0 immediately; a following full codeword yields the correct result.
